// File: rtl/test_status_port.sv
// Test status port: a memory-mapped TOHOST/CHECKPOINT/CYCLES register block
// with a pass/fail/timeout result FSM and a re-armable cycle watchdog.
module test_status_port #(
    parameter logic [31:0] BASE_ADDR      = 32'h8000_1000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic [31:0] error,
    output logic        done,
    output logic        pass
);

    localparam logic [1:0]  RUNNING  = 2'd0;
    localparam logic [1:0]  PASSED   = 2'd1;
    localparam logic [1:0]  FAILED   = 2'd2;
    localparam logic [1:0]  TIMEOUT  = 2'd3;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    logic [1:0]  state;
    logic [31:0] tohost;
    logic [31:0] checkpoint;
    logic [31:0] cycles;

    logic        accept;
    logic [29:0] word_off;
    logic        sel_tohost;
    logic        sel_checkpoint;
    logic        sel_cycles;
    logic        wr_tohost;
    logic        wr_checkpoint;
    logic [31:0] cycles_next;
    logic        timeout_hit;
    logic [31:0] read_word;
    logic        unused_addr_bits;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == ALL_ONES) ? v : v + 32'd1;
    endfunction

    assign unused_addr_bits = ^addr[1:0];

    always_comb begin
        // A new access is taken only while no ack is outstanding, which
        // spaces back-to-back requests to at most one ack every other cycle.
        accept         = req && !ack;
        word_off       = addr[31:2] - BASE_ADDR[31:2];
        sel_tohost     = (word_off == 30'd0);
        sel_checkpoint = (word_off == 30'd1);
        sel_cycles     = (word_off == 30'd2);
        wr_tohost      = accept && we && sel_tohost;
        wr_checkpoint  = accept && we && sel_checkpoint;
        cycles_next    = sat_inc(cycles);
        timeout_hit    = (state == RUNNING) && (cycles_next >= TIMEOUT_CYCLES);

        read_word = 32'd0;
        if (sel_tohost) begin
            read_word = tohost;
        end else if (sel_checkpoint) begin
            read_word = checkpoint;
        end else if (sel_cycles) begin
            read_word = cycles;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack        <= 1'b0;
            rdata      <= 32'd0;
            tohost     <= 32'd0;
            checkpoint <= 32'd0;
        end else begin
            ack   <= accept;
            rdata <= (accept && !we) ? read_word : 32'd0;
            if (wr_tohost) begin
                tohost <= wdata;
            end
            if (wr_checkpoint) begin
                checkpoint <= wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUNNING;
            cycles <= 32'd0;
            done   <= 1'b0;
            pass   <= 1'b0;
            error  <= 32'd0;
        end else if (state == RUNNING) begin
            cycles <= wr_checkpoint ? 32'd0 : cycles_next;
            // A committing TOHOST or CHECKPOINT write takes precedence over
            // the watchdog firing on the same edge.
            if (wr_tohost && wdata[0]) begin
                done <= 1'b1;
                if (wdata == 32'd1) begin
                    state <= PASSED;
                    pass  <= 1'b1;
                    error <= 32'd0;
                end else begin
                    state <= FAILED;
                    pass  <= 1'b0;
                    error <= wdata >> 1;
                end
            end else if (timeout_hit && !wr_tohost && !wr_checkpoint) begin
                state <= TIMEOUT;
                done  <= 1'b1;
                pass  <= 1'b0;
                error <= ALL_ONES;
            end
        end
    end

endmodule

// File: tb/tb_test_status_port.sv
// Self-checking bench for test_status_port: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model of the register block.
module tb_test_status_port;

    localparam logic [31:0] BASE = 32'h8000_1000;
    localparam int          TMO  = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] error;
    logic        done;
    logic        pass;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: status 0=running 1=passed 2=failed 3=timeout
    int          m_status;
    longint      m_cycles;
    logic [31:0] m_tohost;
    logic [31:0] m_chk;
    logic [31:0] m_error;
    logic        m_ack;
    logic [31:0] m_rdata;

    test_status_port #(
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (32'd50)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .ack   (ack),
        .rdata (rdata),
        .error (error),
        .done  (done),
        .pass  (pass)
    );

    always #5 clk = ~clk;

    // Advance one clock edge, updating the model from the inputs being driven.
    task automatic cycle();
        logic        acc;
        logic        wr;
        int          kind;
        longint      off;
        logic [31:0] rd;
        if (reset) begin
            m_status = 0;
            m_cycles = 0;
            m_tohost = 32'd0;
            m_chk    = 32'd0;
            m_error  = 32'd0;
            m_ack    = 1'b0;
            m_rdata  = 32'd0;
        end else begin
            off  = longint'({addr[31:2], 2'b00}) - longint'(BASE);
            kind = (off == 0) ? 0 : (off == 4) ? 1 : (off == 8) ? 2 : 3;
            acc  = req && !m_ack;
            wr   = acc && we;
            rd   = 32'd0;
            if (acc && !we) begin
                case (kind)
                    0:       rd = m_tohost;
                    1:       rd = m_chk;
                    2:       rd = m_cycles[31:0];
                    default: rd = 32'd0;
                endcase
            end
            if (m_status == 0) begin
                if (wr && kind == 1) m_cycles = 0;
                else if (m_cycles < 64'h0000_0000_FFFF_FFFF) m_cycles = m_cycles + 1;
                if (wr && kind == 0 && wdata[0]) begin
                    m_status = (wdata == 32'd1) ? 1 : 2;
                    m_error  = (wdata == 32'd1) ? 32'd0 : (wdata >> 1);
                end else if (m_cycles >= TMO && !(wr && kind == 0)) begin
                    m_status = 3;
                    m_error  = 32'hFFFF_FFFF;
                end
            end
            if (wr && kind == 0) m_tohost = wdata;
            if (wr && kind == 1) m_chk = wdata;
            m_ack   = acc;
            m_rdata = rd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        req   = 1'b0;
        we    = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic got_ack, output logic [31:0] got_rdata);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        cycle();
        got_ack   = ack;
        got_rdata = rdata;
        req = 1'b0;
        we  = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        req = 1'b1; we = 1'b1; addr = BASE; wdata = 32'd1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (ack !== 1'b0 || rdata !== 32'd0 || done !== 1'b0 || pass !== 1'b0 || error !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: ack=%0b rdata=%h done=%0b pass=%0b error=%h, want all zero",
                         ack, rdata, done, pass, error);
            end
        end
        reset = 1'b0;
        cycle();
        n_checks++;
        if (ack !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ack: got %0b want 1", ack);
        end
        n_checks++;
        if (pass !== 1'b1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_write: done=%0b pass=%0b want 1 1", done, pass);
        end
        req = 1'b0;
        do_reset();
    endtask

    task automatic test_pass();
        logic        a;
        logic [31:0] r;
        do_reset();
        idle(9);
        req = 1'b1; we = 1'b1; addr = BASE; wdata = 32'd1;
        cycle();
        n_checks++;
        if (ack !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_ack: got %0b want 1", ack);
        end
        req = 1'b0; we = 1'b0;
        cycle();
        n_checks++;
        if (ack !== 1'b0 || done !== 1'b1 || pass !== 1'b1 || error !== 32'd0) begin
            n_fail++;
            $display("FAIL pass_result: ack=%0b done=%0b pass=%0b error=%h want 0 1 1 0", ack, done, pass, error);
        end
        access(1'b1, BASE, 32'd7, a, r);
        n_checks++;
        if (a !== 1'b1 || error !== 32'd0 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_sticky: ack=%0b error=%h pass=%0b want 1 0 1", a, error, pass);
        end
    endtask

    task automatic test_fail();
        logic        a;
        logic [31:0] r;
        do_reset();
        access(1'b1, BASE, 32'h0000_000B, a, r);
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b0 || error !== 32'd5) begin
            n_fail++;
            $display("FAIL fail_result: done=%0b pass=%0b error=%h want 1 0 5", done, pass, error);
        end
        access(1'b0, BASE, 32'd0, a, r);
        n_checks++;
        if (a !== 1'b1 || r !== 32'h0000_000B) begin
            n_fail++;
            $display("FAIL fail_read_tohost: ack=%0b rdata=%h want 1 0000000b", a, r);
        end
    endtask

    task automatic test_timeout();
        logic        a;
        logic [31:0] r;
        do_reset();
        idle(49);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: done=%0b want 0 at cycles=49", done);
        end
        idle(1);
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b0 || error !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL timeout_result: done=%0b pass=%0b error=%h want 1 0 ffffffff", done, pass, error);
        end
        idle(5);
        access(1'b0, BASE + 32'h8, 32'd0, a, r);
        n_checks++;
        if (a !== 1'b1 || r !== 32'd50) begin
            n_fail++;
            $display("FAIL timeout_cycles: ack=%0b rdata=%0d want 1 50", a, r);
        end
    endtask

    task automatic test_checkpoint();
        logic        a;
        logic [31:0] r;
        do_reset();
        idle(40);
        access(1'b1, BASE + 32'h4, 32'hCAFE_0001, a, r);
        idle(48);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL checkpoint_rearm: done=%0b want 0", done);
        end
        req = 1'b1; we = 1'b1; addr = BASE; wdata = 32'd1;
        cycle();
        req = 1'b0; we = 1'b0;
        cycle();
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1 || error !== 32'd0) begin
            n_fail++;
            $display("FAIL checkpoint_race: done=%0b pass=%0b error=%h want 1 1 0", done, pass, error);
        end
        access(1'b1, BASE + 32'h4, 32'h0000_1234, a, r);
        access(1'b0, BASE + 32'h8, 32'd0, a, r);
        n_checks++;
        if (r !== 32'd50) begin
            n_fail++;
            $display("FAIL checkpoint_terminal_cycles: rdata=%0d want 50", r);
        end
        access(1'b0, BASE + 32'h4, 32'd0, a, r);
        n_checks++;
        if (r !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL checkpoint_terminal_store: rdata=%h want 00001234", r);
        end
    endtask

    task automatic test_unmapped();
        logic        a;
        logic [31:0] r;
        logic        prev;
        int          acks;
        do_reset();
        access(1'b0, BASE + 32'hC, 32'd0, a, r);
        n_checks++;
        if (a !== 1'b1 || r !== 32'd0) begin
            n_fail++;
            $display("FAIL unmapped_read: ack=%0b rdata=%h want 1 0", a, r);
        end
        access(1'b1, BASE + 32'h8, 32'hDEAD_BEEF, a, r);
        access(1'b0, BASE + 32'h8, 32'd0, a, r);
        n_checks++;
        if (r !== 32'd4 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL cycles_readonly: rdata=%0d done=%0b want 4 0", r, done);
        end
        req = 1'b1; we = 1'b0; addr = BASE + 32'h8;
        prev = 1'b0;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            n_checks++;
            if (ack === 1'b1 && prev === 1'b1) begin
                n_fail++;
                $display("FAIL back_to_back: ack=1 on consecutive cycles at step %0d", i);
            end
            if (ack === 1'b1) acks++;
            prev = ack;
        end
        req = 1'b0;
        n_checks++;
        if (acks != 6) begin
            n_fail++;
            $display("FAIL back_to_back_count: got %0d acks want 6", acks);
        end
        cycle();
    endtask

    task automatic test_reset_terminal();
        logic        a;
        logic [31:0] r;
        do_reset();
        access(1'b1, BASE, 32'd7, a, r);
        n_checks++;
        if (error !== 32'd3 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL terminal_fail: error=%h done=%0b want 3 1", error, done);
        end
        idle(3);
        do_reset();
        n_checks++;
        if (done !== 1'b0 || error !== 32'd0 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL terminal_reset: done=%0b error=%h pass=%0b want 0 0 0", done, error, pass);
        end
        access(1'b0, BASE + 32'h8, 32'd0, a, r);
        n_checks++;
        if (a !== 1'b1 || r !== 32'd0) begin
            n_fail++;
            $display("FAIL terminal_reset_cycles: ack=%0b rdata=%0d want 1 0", a, r);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            req   = ($urandom_range(0, 1) == 1);
            we    = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 6))
                0, 1:    addr = BASE;
                2, 3:    addr = BASE + 32'h4;
                4:       addr = BASE + 32'h8;
                5:       addr = BASE + 32'hC + 32'($urandom_range(0, 3));
                default: addr = $urandom;
            endcase
            wdata = $urandom & 32'hFFFF_FFFE;
            if ($urandom_range(0, 7) == 0) wdata = wdata | 32'd1;
            if ($urandom_range(0, 15) == 0) wdata = 32'd1;
            cycle();
            n_checks++;
            if (ack !== m_ack || rdata !== m_rdata || done !== (m_status != 0) ||
                pass !== (m_status == 1) || error !== m_error) begin
                n_fail++;
                $display("FAIL random_step %0d: ack=%0b rdata=%h done=%0b pass=%0b error=%h; want %0b %h %0b %0b %h",
                         i, ack, rdata, done, pass, error,
                         m_ack, m_rdata, (m_status != 0), (m_status == 1), m_error);
            end
        end
        reset = 1'b0;
        req   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        cycle();
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_checkpoint();
        test_unmapped();
        test_reset_terminal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/test_status_port.md
TEST_STATUS_PORT -- requirements
Module: test_status_port

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_1000, meaning the byte address of register block word 0.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the watchdog limit in clk cycles; legal range is 2 .. 2^32-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req, input, 1 bit: bus request, held high by the master until ack.
REQ-006 SHALL have port we, input, 1 bit: 1 = write, 0 = read; valid while req is high.
REQ-007 SHALL have port addr, input, 32 bits: byte address, word-aligned; addr[1:0] are ignored.
REQ-008 SHALL have port wdata, input, 32 bits: write data.
REQ-009 SHALL have port ack, output, 1 bit: one-cycle response strobe.
REQ-010 SHALL have port rdata, output, 32 bits: read data, valid only while ack is high.
REQ-011 SHALL have port error, output, 32 bits: 0 = no failure; otherwise the failing test number, or 32'hFFFF_FFFF for a timeout.
REQ-012 SHALL have port done, output, 1 bit: test run finished (pass, fail or timeout).
REQ-013 SHALL have port pass, output, 1 bit: test run finished successfully.

Function
REQ-014 SHALL decode three words: TOHOST at BASE+0x0 (write; reads return last accepted value), CHECKPOINT at BASE+0x4 (read/write), CYCLES at BASE+0x8 (read-only).
REQ-015 SHALL assert ack for exactly one cycle, in the cycle after req is sampled high, when no ack is currently high; a back-to-back request gets ack on every other cycle at most.
REQ-016 SHALL perform a write's register update on the same edge that raises ack.
REQ-017 SHALL acknowledge accesses to other addresses, or writes to CYCLES, with rdata=0 and no side effects.
REQ-018 SHALL drive rdata=0 whenever ack is low.
REQ-019 SHALL implement FSM states RUNNING, PASSED, FAILED, TIMEOUT; reset enters RUNNING.
REQ-020 RUNNING + TOHOST write with value 1 SHALL move the FSM to PASSED, with done=1, pass=1, error=0.
REQ-021 RUNNING + TOHOST write with an odd value v != 1 SHALL move the FSM to FAILED, with done=1, pass=0, error=v>>1 (logical shift).
REQ-022 RUNNING + TOHOST write with an even value SHALL store the value but leave state and outputs unchanged; this covers value 0.
REQ-023 PASSED, FAILED and TIMEOUT SHALL be terminal until reset; later TOHOST writes are acked and ignored, and the first result sticks.
REQ-024 CYCLES SHALL increment by 1 each cycle while in RUNNING, freeze in terminal states, and saturate at 32'hFFFF_FFFF.
REQ-025 RUNNING SHALL move to TIMEOUT on the edge where CYCLES would reach TIMEOUT_CYCLES, with done=1, pass=0, error=32'hFFFF_FFFF.
REQ-026 Simultaneous TOHOST write commit and timeout edge: the write SHALL win, and TIMEOUT SHALL NOT be entered.
REQ-027 A CHECKPOINT write SHALL store wdata and restart the CYCLES counter at 0; the watchdog is re-armed.
REQ-028 CHECKPOINT writes in terminal states SHALL store wdata but SHALL NOT alter CYCLES.
REQ-029 done, pass and error SHALL be registered outputs that change only on clk edges.

Reset
REQ-030 reset=1 at a clk edge SHALL force: FSM=RUNNING, ack=0, rdata=0, error=0, done=0, pass=0, TOHOST=0, CHECKPOINT=0, CYCLES=0.
REQ-031 reset SHALL override any in-flight request; a req held across reset release is acked on the first cycle after release.
REQ-032 reset asserted in any terminal state SHALL return the block to RUNNING with all counters cleared.

Verification
REQ-033 Write TOHOST=1 at cycle 10 -> ack at cycle 11; done=1, pass=1, error=0 from cycle 12; later write of 7 -> error stays 0.
REQ-034 Write TOHOST=0x0000_000B -> done=1, pass=0, error=5; read TOHOST -> rdata=0x0000_000B.
REQ-035 TIMEOUT_CYCLES=50, no writes -> done=1, error=32'hFFFF_FFFF once CYCLES hits 50; read CYCLES -> 50.
REQ-036 TIMEOUT_CYCLES=50, CHECKPOINT write at CYCLES=40 -> no timeout before 50 cycles after that write; TOHOST=1 write committing on the timeout edge -> PASSED.
REQ-037 Read of BASE+0xC and write to CYCLES -> single-cycle ack, rdata=0, no state change; back-to-back reqs -> ack never high on two consecutive cycles.
REQ-038 Reset pulse while FAILED (error=3) -> the cycle after reset: done=0, error=0, CYCLES=0, FSM=RUNNING.
